// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
//   Machine-mode CSR register file for the RV32I core. It sits behind the
//   trap controller and serves the pipeline's CSR read/write port.
//
//   Ports
//     clk_i, n_rst_i            clock, synchronous active-high reset
//     raddr_i / rdata_o         CSR read address, combinational read data
//     we_i, waddr_i, wdata_i    software write (value already computed)
//     instret_i                 one instruction retired this cycle
//     irq_*_i                   level interrupt lines (external/timer/sw)
//     set_cause_i, trap_cause_i, ie_type_i   mcause update strobe
//     set_epc_i, epc_i          mepc update strobe
//     set_mtval_i, mtval_i      mtval update strobe
//     mstatus_ie_clear_i/set_i  trap entry / mret handling of MIE/MPIE
//     mstatus_ie_o, mie_*_o, mip_*_o, mtvec_o, epc_o   state to trap logic
// ---------------------------------------------------------------------------
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  input  logic        set_cause_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        ie_type_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] epc_o
);

  // Despite its name, n_rst_i is active-high; RST_EN names that level.
  localparam logic RST_EN = 1'b1;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  logic        rst;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]  mie_q, mie_d;            // {external, timer, sw}
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic        mcause_int_q, mcause_int_d;
  logic [3:0]  mcause_code_q, mcause_code_d;
  logic [31:0] mtval_q, mtval_d;
  logic [2:0]  mip_q, mip_d;            // {external, timer, sw}
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
  logic wr_mcause, wr_mtval;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  // The low two bits of the trap PC are always discarded.
  logic unused_epc_bits;

  assign rst             = (n_rst_i == RST_EN);
  assign unused_epc_bits = ^epc_i[1:0];

  assign wr_mstatus   = we_i && (waddr_i == A_MSTATUS);
  assign wr_mie       = we_i && (waddr_i == A_MIE);
  assign wr_mtvec     = we_i && (waddr_i == A_MTVEC);
  assign wr_mscratch  = we_i && (waddr_i == A_MSCRATCH);
  assign wr_mepc      = we_i && (waddr_i == A_MEPC);
  assign wr_mcause    = we_i && (waddr_i == A_MCAUSE);
  assign wr_mtval     = we_i && (waddr_i == A_MTVAL);
  assign wr_mcycle    = we_i && (waddr_i == A_MCYCLE);
  assign wr_mcycleh   = we_i && (waddr_i == A_MCYCLEH);
  assign wr_minstret  = we_i && (waddr_i == A_MINSTRET);
  assign wr_minstreth = we_i && (waddr_i == A_MINSTRETH);

  // Next-state logic. Trap strobes are tested before the software write so
  // that a same-cycle software write to the same register is dropped.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    if (mstatus_ie_clear_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mstatus_ie_set_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie_d  = wdata_i[3];
      mstatus_mpie_d = wdata_i[7];
    end

    mie_d = mie_q;
    if (wr_mie) begin
      mie_d = {wdata_i[11], wdata_i[7], wdata_i[3]};
    end

    mtvec_d = wr_mtvec ? wdata_i : mtvec_q;
    mscratch_d = wr_mscratch ? wdata_i : mscratch_q;

    mepc_d = mepc_q;
    if (set_epc_i) begin
      mepc_d = {epc_i[31:2], 2'b00};
    end else if (wr_mepc) begin
      mepc_d = {wdata_i[31:2], 2'b00};
    end

    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    if (set_cause_i) begin
      mcause_int_d  = ie_type_i;
      mcause_code_d = trap_cause_i;
    end else if (wr_mcause) begin
      mcause_int_d  = wdata_i[31];
      mcause_code_d = wdata_i[3:0];
    end

    mtval_d = mtval_q;
    if (set_mtval_i) begin
      mtval_d = mtval_i;
    end else if (wr_mtval) begin
      mtval_d = wdata_i;
    end

    mip_d = {irq_external_i, irq_timer_i, irq_sw_i};

    // A write to either counter half suppresses that cycle's increment.
    if (wr_mcycle) begin
      mcycle_d = {mcycle_q[63:32], wdata_i};
    end else if (wr_mcycleh) begin
      mcycle_d = {wdata_i, mcycle_q[31:0]};
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end

    if (wr_minstret) begin
      minstret_d = {minstret_q[63:32], wdata_i};
    end else if (wr_minstreth) begin
      minstret_d = {wdata_i, minstret_q[31:0]};
    end else if (instret_i) begin
      minstret_d = minstret_q + 64'd1;
    end else begin
      minstret_d = minstret_q;
    end
  end

  // State registers; reset overrides any same-cycle write or strobe.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 3'b000;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_int_q   <= 1'b0;
      mcause_code_q  <= 4'h0;
      mtval_q        <= 32'h0;
      mip_q          <= 3'b000;
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_int_q   <= mcause_int_d;
      mcause_code_q  <= mcause_code_d;
      mtval_q        <= mtval_d;
      mip_q          <= mip_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  // Combinational read port from current state only, so a read in the same
  // cycle as a write sees the old value.
  always_comb begin
    rdata_o = 32'h0;
    case (raddr_i)
      A_MSTATUS:   rdata_o = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      A_MISA:      rdata_o = MISA_VALUE;
      A_MIE:       rdata_o = {20'h0, mie_q[2], 3'b000, mie_q[1], 3'b000, mie_q[0], 3'b000};
      A_MTVEC:     rdata_o = mtvec_q;
      A_MSCRATCH:  rdata_o = mscratch_q;
      A_MEPC:      rdata_o = mepc_q;
      A_MCAUSE:    rdata_o = {mcause_int_q, 27'h0, mcause_code_q};
      A_MTVAL:     rdata_o = mtval_q;
      A_MIP:       rdata_o = {20'h0, mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000};
      A_MCYCLE,
      A_CYCLE:     rdata_o = mcycle_q[31:0];
      A_MCYCLEH,
      A_CYCLEH:    rdata_o = mcycle_q[63:32];
      A_MINSTRET,
      A_INSTRET:   rdata_o = minstret_q[31:0];
      A_MINSTRETH,
      A_INSTRETH:  rdata_o = minstret_q[63:32];
      A_MVENDORID,
      A_MARCHID,
      A_MIMPID:    rdata_o = 32'h0;
      A_MHARTID:   rdata_o = HART_ID;
      default:     rdata_o = 32'h0;
    endcase
  end

  assign mstatus_ie_o   = mstatus_mie_q;
  assign mie_external_o = mie_q[2];
  assign mie_timer_o    = mie_q[1];
  assign mie_sw_o       = mie_q[0];
  assign mip_external_o = mip_q[2];
  assign mip_timer_o    = mip_q[1];
  assign mip_sw_o       = mip_q[0];
  assign mtvec_o        = mtvec_q;
  assign epc_o          = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
//   Self-checking bench for csr_file. Each scenario task drives stimulus,
//   pushes the values it expects into a queue, then pops them and compares
//   against what the DUT shows.
// ---------------------------------------------------------------------------
module tb_csr_file;

  logic        clk;
  logic        n_rst;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        instret;
  logic        irq_ext, irq_tmr, irq_sw;
  logic        set_cause;
  logic [3:0]  trap_cause;
  logic        ie_type;
  logic        set_epc;
  logic [31:0] epc;
  logic        set_mtval;
  logic [31:0] mtval;
  logic        ie_clear, ie_set;
  logic        mstatus_ie;
  logic        mie_ext, mie_tmr, mie_sw;
  logic        mip_ext, mip_tmr, mip_sw;
  logic [31:0] mtvec_out, epc_out;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] got;

  csr_file #(.MTVEC_RESET(32'h0000_0100), .HART_ID(32'd0)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .raddr_i(raddr), .rdata_o(rdata),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .instret_i(instret),
    .irq_external_i(irq_ext), .irq_timer_i(irq_tmr), .irq_sw_i(irq_sw),
    .set_cause_i(set_cause), .trap_cause_i(trap_cause), .ie_type_i(ie_type),
    .set_epc_i(set_epc), .epc_i(epc),
    .set_mtval_i(set_mtval), .mtval_i(mtval),
    .mstatus_ie_clear_i(ie_clear), .mstatus_ie_set_i(ie_set),
    .mstatus_ie_o(mstatus_ie),
    .mie_external_o(mie_ext), .mie_timer_o(mie_tmr), .mie_sw_o(mie_sw),
    .mip_external_o(mip_ext), .mip_timer_o(mip_tmr), .mip_sw_o(mip_sw),
    .mtvec_o(mtvec_out), .epc_o(epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    step();
    step();
    n_rst = 1'b0;
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4000_0100);
    exp_q.push_back(32'h0);
    read_csr(12'h305, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL reset_mtvec: got %h want %h", got, exp_v); end
    read_csr(12'h300, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL reset_mstatus: got %h want %h", got, exp_v); end
    read_csr(12'h342, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL reset_mcause: got %h want %h", got, exp_v); end
    read_csr(12'h301, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL misa: got %h want %h", got, exp_v); end
    read_csr(12'hB00, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL reset_mcycle: got %h want %h", got, exp_v); end
    compared++;
    if (mtvec_out !== 32'h0000_0100) begin mismatched++; $display("[TB] FAIL reset_mtvec_o: got %h want 00000100", mtvec_out); end
  endtask

  task automatic test_trap_entry();
    write_csr(12'h300, 32'h0000_0008);
    compared++;
    if (mstatus_ie !== 1'b1) begin mismatched++; $display("[TB] FAIL mie_after_write: got %b want 1", mstatus_ie); end
    set_cause = 1'b1; ie_type = 1'b1; trap_cause = 4'hB;
    set_epc = 1'b1; epc = 32'h0000_1236;
    set_mtval = 1'b1; mtval = 32'hDEAD_BEEF;
    ie_clear = 1'b1;
    exp_q.push_back(32'h8000_000B);
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0000_0080);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    set_cause = 1'b0; set_epc = 1'b0; set_mtval = 1'b0; ie_clear = 1'b0;
    read_csr(12'h342, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL trap_mcause: got %h want %h", got, exp_v); end
    read_csr(12'h341, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL trap_mepc: got %h want %h", got, exp_v); end
    read_csr(12'h300, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL trap_mstatus: got %h want %h", got, exp_v); end
    read_csr(12'h343, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL trap_mtval: got %h want %h", got, exp_v); end
    compared++;
    if (mstatus_ie !== 1'b0 || epc_out !== 32'h0000_1234) begin
      mismatched++; $display("[TB] FAIL trap_outputs: got ie=%b epc=%h want ie=0 epc=00001234", mstatus_ie, epc_out);
    end
    ie_set = 1'b1;
    exp_q.push_back(32'h0000_0088);
    step();
    ie_set = 1'b0;
    read_csr(12'h300, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mret_mstatus: got %h want %h", got, exp_v); end
    // Both strobes together: clear takes priority (MPIE<=MIE=1, MIE<=0).
    ie_set = 1'b1; ie_clear = 1'b1;
    exp_q.push_back(32'h0000_0080);
    step();
    ie_set = 1'b0; ie_clear = 1'b0;
    read_csr(12'h300, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL both_strobes: got %h want %h", got, exp_v); end
  endtask

  task automatic test_conflict();
    we = 1'b1; waddr = 12'h341; wdata = 32'hAAAA_AAA8;
    set_epc = 1'b1; epc = 32'h0000_0400;
    exp_q.push_back(32'h0000_0400);
    // Read-during-write must show the old mepc.
    read_csr(12'h341, got); compared++;
    if (got !== 32'h0000_1234) begin mismatched++; $display("[TB] FAIL read_during_write: got %h want 00001234", got); end
    step();
    we = 1'b0; set_epc = 1'b0;
    read_csr(12'h341, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL epc_conflict: got %h want %h", got, exp_v); end
    // Trap clear beats a software write to mstatus (0x80 -> MPIE=0, MIE=0).
    we = 1'b1; waddr = 12'h300; wdata = 32'h0000_0088; ie_clear = 1'b1;
    exp_q.push_back(32'h0000_0000);
    step();
    we = 1'b0; ie_clear = 1'b0;
    read_csr(12'h300, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mstatus_conflict: got %h want %h", got, exp_v); end
    write_csr(12'h341, 32'hAAAA_AAAB);
    exp_q.push_back(32'hAAAA_AAA8);
    read_csr(12'h341, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mepc_align: got %h want %h", got, exp_v); end
    write_csr(12'h300, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0088);
    read_csr(12'h300, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mstatus_mask: got %h want %h", got, exp_v); end
  endtask

  task automatic test_interrupts();
    write_csr(12'h304, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0888);
    read_csr(12'h304, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mie_mask: got %h want %h", got, exp_v); end
    compared++;
    if ({mie_ext, mie_tmr, mie_sw} !== 3'b111) begin mismatched++; $display("[TB] FAIL mie_outputs: got %b want 111", {mie_ext, mie_tmr, mie_sw}); end
    irq_tmr = 1'b1;
    #1;
    compared++;
    if (mip_tmr !== 1'b0) begin mismatched++; $display("[TB] FAIL mip_early: got %b want 0", mip_tmr); end
    exp_q.push_back(32'h0000_0080);
    step();
    compared++;
    if (mip_tmr !== 1'b1) begin mismatched++; $display("[TB] FAIL mip_timer_o: got %b want 1", mip_tmr); end
    read_csr(12'h344, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mip_timer: got %h want %h", got, exp_v); end
    irq_ext = 1'b1; irq_sw = 1'b1; irq_tmr = 1'b0;
    exp_q.push_back(32'h0000_0808);
    step();
    read_csr(12'h344, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mip_ext_sw: got %h want %h", got, exp_v); end
    irq_ext = 1'b0; irq_sw = 1'b0;
    step();
  endtask

  task automatic test_counters();
    write_csr(12'hB80, 32'h0);
    write_csr(12'hB00, 32'd100);
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd103);
    read_csr(12'hB00, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mcycle_write: got %h want %h", got, exp_v); end
    step(); step(); step();
    read_csr(12'hC00, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mcycle_count: got %h want %h", got, exp_v); end
    // Wrap: FFFFFFFF_FFFFFFFE -> FFFFFFFF_FFFFFFFF -> 0.
    write_csr(12'hB80, 32'hFFFF_FFFF);
    write_csr(12'hB00, 32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    read_csr(12'hB00, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL pre_wrap_lo: got %h want %h", got, exp_v); end
    read_csr(12'hB80, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL pre_wrap_hi: got %h want %h", got, exp_v); end
    step(); step();
    read_csr(12'hB00, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL wrap_lo: got %h want %h", got, exp_v); end
    read_csr(12'hC80, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL wrap_hi: got %h want %h", got, exp_v); end
    // minstret: write cycle suppresses the retire increment.
    write_csr(12'hB82, 32'h0);
    instret = 1'b1;
    write_csr(12'hB02, 32'd5);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'h0);
    read_csr(12'hB02, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL minstret_write: got %h want %h", got, exp_v); end
    step(); step(); step();
    instret = 1'b0;
    step();
    read_csr(12'hC02, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL minstret_count: got %h want %h", got, exp_v); end
    read_csr(12'hC82, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL minstreth: got %h want %h", got, exp_v); end
  endtask

  task automatic test_unmapped();
    write_csr(12'h340, 32'h1234_5678);
    write_csr(12'h7C0, 32'hCAFE_F00D);
    write_csr(12'h301, 32'h0);
    write_csr(12'hF14, 32'h5555_5555);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h4000_0100);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    read_csr(12'h7C0, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL unmapped_read: got %h want %h", got, exp_v); end
    read_csr(12'h340, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mscratch_kept: got %h want %h", got, exp_v); end
    read_csr(12'h301, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL misa_ro: got %h want %h", got, exp_v); end
    read_csr(12'hF14, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mhartid: got %h want %h", got, exp_v); end
    read_csr(12'hF11, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL mvendorid: got %h want %h", got, exp_v); end
  endtask

  task automatic test_reset_mid_op();
    write_csr(12'h305, 32'h0000_2001);
    n_rst = 1'b1;
    we = 1'b1; waddr = 12'h340; wdata = 32'hDEAD_0000;
    set_epc = 1'b1; epc = 32'h0000_0888;
    step();
    n_rst = 1'b0; we = 1'b0; set_epc = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0);
    read_csr(12'h340, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL rst_mscratch: got %h want %h", got, exp_v); end
    read_csr(12'h341, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL rst_mepc: got %h want %h", got, exp_v); end
    read_csr(12'h305, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL rst_mtvec: got %h want %h", got, exp_v); end
    read_csr(12'h304, got); exp_v = exp_q.pop_front(); compared++;
    if (got !== exp_v) begin mismatched++; $display("[TB] FAIL rst_mie: got %h want %h", got, exp_v); end
  endtask

  initial begin
    n_rst = 1'b1; raddr = 12'h0; we = 1'b0; waddr = 12'h0; wdata = 32'h0;
    instret = 1'b0; irq_ext = 1'b0; irq_tmr = 1'b0; irq_sw = 1'b0;
    set_cause = 1'b0; trap_cause = 4'h0; ie_type = 1'b0;
    set_epc = 1'b0; epc = 32'h0; set_mtval = 1'b0; mtval = 32'h0;
    ie_clear = 1'b0; ie_set = 1'b0;
    test_reset();
    test_trap_entry();
    test_conflict();
    test_interrupts();
    test_counters();
    test_unmapped();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
